// File: rtl/probe_trace_buffer_pkg.sv
// Shared types and helpers for the probe trace buffer: FSM state encoding
// and a width helper that never returns zero.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_DEPTH    = 16;

    // Index width for n items, kept at least one bit so single-item ports stay legal.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/probe_trace_buffer_ram.sv
// Simple dual-port trace storage: one synchronous write port, one synchronous
// read port whose output register resets to zero and holds between reads.
module trace_ram #(
    parameter int DW    = 128,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/probe_trace_buffer.sv
// Circular trace capture of CHANNELS probe words with masked trigger,
// post-trigger window, and oldest-first playback over a read handshake.
module probe_trace_buffer
    import trace_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [CHANNELS*WIDTH-1:0]          probe_in,
    input  logic                               probe_valid,
    input  logic                               arm,
    input  logic [clog2_min1(CHANNELS)-1:0]    trig_chan,
    input  logic [WIDTH-1:0]                   trig_value,
    input  logic [WIDTH-1:0]                   trig_mask,
    input  logic [$clog2(DEPTH):0]             post_count,
    input  logic                               rd_en,
    output logic [CHANNELS*WIDTH-1:0]          rd_data,
    output logic                               rd_valid,
    output logic [$clog2(DEPTH):0]             rd_left,
    output logic                               armed,
    output logic                               triggered,
    output logic                               done
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CNT = AW + 1;
    localparam int CW  = clog2_min1(CHANNELS);

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT-1:0]     fill_q, fill_d;
    logic [CNT-1:0]     remain_q, remain_d;
    logic [CNT-1:0]     post_q, post_d;
    logic [CNT-1:0]     rd_left_q, rd_left_d;
    logic [CW-1:0]      trig_chan_q, trig_chan_d;
    logic [WIDTH-1:0]   trig_value_q, trig_value_d;
    logic [WIDTH-1:0]   trig_mask_q, trig_mask_d;
    logic               triggered_q, triggered_d;
    logic               rd_valid_q, rd_valid_d;
    logic               armed_q, armed_d;
    logic               done_q, done_d;

    logic               start;
    logic               enter_done;
    logic               hit;
    logic               we;
    logic               re;
    logic [WIDTH-1:0]   sel_chan;

    always_comb begin
        sel_chan = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (trig_chan_q == CW'(k)) begin
                sel_chan = probe_in[k*WIDTH +: WIDTH];
            end
        end
        hit   = (((sel_chan ^ trig_value_q) & trig_mask_q) == '0);
        start = arm && (state_q == ST_IDLE || state_q == ST_DONE);
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_d       = fill_q;
        remain_d     = remain_q;
        post_d       = post_q;
        rd_left_d    = rd_left_q;
        trig_chan_d  = trig_chan_q;
        trig_value_d = trig_value_q;
        trig_mask_d  = trig_mask_q;
        triggered_d  = triggered_q;
        enter_done   = 1'b0;
        we           = 1'b0;
        re           = 1'b0;

        if (start) begin
            state_d      = ST_ARMED;
            trig_chan_d  = trig_chan;
            trig_value_d = trig_value;
            trig_mask_d  = trig_mask;
            post_d       = (post_count > CNT'(DEPTH-1)) ? CNT'(DEPTH-1) : post_count;
            wr_ptr_d     = '0;
            fill_d       = '0;
            rd_left_d    = '0;
            triggered_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ARMED, ST_POST: begin
                    if (probe_valid) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        if (fill_q != CNT'(DEPTH)) begin
                            fill_d = fill_q + CNT'(1);
                        end
                        if (state_q == ST_ARMED) begin
                            if (hit) begin
                                triggered_d = 1'b1;
                                if (post_q == '0) begin
                                    enter_done = 1'b1;
                                end else begin
                                    state_d  = ST_POST;
                                    remain_d = post_q;
                                end
                            end
                        end else begin
                            remain_d = remain_q - CNT'(1);
                            if (remain_q == CNT'(1)) begin
                                enter_done = 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (rd_en && rd_left_q != '0) begin
                        re        = 1'b1;
                        rd_ptr_d  = rd_ptr_q + AW'(1);
                        rd_left_d = rd_left_q - CNT'(1);
                        if (rd_left_q == CNT'(1)) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Oldest entry sits at the write pointer only once the ring has wrapped.
        if (enter_done) begin
            state_d   = ST_DONE;
            rd_left_d = fill_d;
            rd_ptr_d  = (fill_d == CNT'(DEPTH)) ? wr_ptr_d : '0;
        end

        rd_valid_d = re;
        armed_d    = (state_d == ST_ARMED) || (state_d == ST_POST);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            remain_q     <= '0;
            post_q       <= '0;
            rd_left_q    <= '0;
            trig_chan_q  <= '0;
            trig_value_q <= '0;
            trig_mask_q  <= '0;
            triggered_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            armed_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            remain_q     <= remain_d;
            post_q       <= post_d;
            rd_left_q    <= rd_left_d;
            trig_chan_q  <= trig_chan_d;
            trig_value_q <= trig_value_d;
            trig_mask_q  <= trig_mask_d;
            triggered_q  <= triggered_d;
            rd_valid_q   <= rd_valid_d;
            armed_q      <= armed_d;
            done_q       <= done_d;
        end
    end

    trace_ram #(
        .DW    (CHANNELS*WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (probe_in),
        .re    (re),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign rd_valid  = rd_valid_q;
    assign rd_left   = rd_left_q;
    assign armed     = armed_q;
    assign triggered = triggered_q;
    assign done      = done_q;

endmodule

// File: tb/tb_probe_trace_buffer.sv
// Directed bench for probe_trace_buffer: table of capture scenarios with
// hand-computed trigger/done points and playback contents, plus reset cases.
module tb_probe_trace_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] probe_in;
    logic         probe_valid;
    logic         arm;
    logic [1:0]   trig_chan;
    logic [31:0]  trig_value;
    logic [31:0]  trig_mask;
    logic [4:0]   post_count;
    logic         rd_en;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic [4:0]   rd_left;
    logic         armed;
    logic         triggered;
    logic         done;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  chan;
        logic [31:0] value;
        logic [31:0] mask;
        logic [4:0]  post;
        bit          gap;
        int          trig_idx;
        int          done_idx;
        int          count;
        int          first;
    } vec_t;

    vec_t vecs[8];

    probe_trace_buffer #(.WIDTH(32), .CHANNELS(4), .DEPTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .probe_in    (probe_in),
        .probe_valid (probe_valid),
        .arm         (arm),
        .trig_chan   (trig_chan),
        .trig_value  (trig_value),
        .trig_mask   (trig_mask),
        .post_count  (post_count),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_left     (rd_left),
        .armed       (armed),
        .triggered   (triggered),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Sample i: ch0 = i, ch1 = i+100, ch2 = ~i, ch3 = 0xABCD0000 | (i << 8).
    function automatic logic [127:0] mk(input int i);
        logic [31:0] c0, c1, c2, c3;
        c0 = 32'(i);
        c1 = 32'(i + 100);
        c2 = ~32'(i);
        c3 = 32'hABCD_0000 | (32'(i) << 8);
        return {c3, c2, c1, c0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " rd_data"},   64'(rd_data[63:0] | rd_data[127:64]), 64'd0);
        check({tag, " rd_valid"},  64'(rd_valid),  64'd0);
        check({tag, " rd_left"},   64'(rd_left),   64'd0);
        check({tag, " armed"},     64'(armed),     64'd0);
        check({tag, " triggered"}, 64'(triggered), 64'd0);
        check({tag, " done"},      64'(done),      64'd0);
    endtask

    task automatic capture_only(input vec_t v);
        int i;
        int got;
        trig_chan  = v.chan;
        trig_value = v.value;
        trig_mask  = v.mask;
        post_count = v.post;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
        check("arm armed", 64'(armed), 64'd1);
        check("arm done", 64'(done), 64'd0);
        check("arm triggered", 64'(triggered), 64'd0);
        check("arm rd_left", 64'(rd_left), 64'd0);
        i   = 0;
        got = -1;
        while (i <= 60 && got < 0) begin
            if (v.gap && triggered) begin
                probe_valid = 1'b0;
                probe_in    = mk(999);
                tick();
            end
            probe_valid = 1'b1;
            probe_in    = mk(i);
            tick();
            check($sformatf("triggered i=%0d", i), 64'(triggered), 64'(i >= v.trig_idx));
            check($sformatf("done i=%0d", i), 64'(done), 64'(i == v.done_idx));
            if (done) got = i;
            i++;
        end
        probe_valid = 1'b0;
        check("done index", 64'(got), 64'(v.done_idx));
        check("armed at done", 64'(armed), 64'd0);
        check("rd_left at done", 64'(rd_left), 64'(v.count));
    endtask

    task automatic read_out(input vec_t v);
        int k;
        logic [127:0] e;
        logic [127:0] last;
        k     = 0;
        last  = '0;
        rd_en = 1'b1;
        repeat (20) begin
            tick();
            if (rd_valid) begin
                e = mk(v.first + k);
                check($sformatf("rd ch0 k=%0d", k), 64'(rd_data[31:0]), 64'(e[31:0]));
                check($sformatf("rd ch3 k=%0d", k), 64'(rd_data[127:96]), 64'(e[127:96]));
                last = rd_data;
                k++;
            end
        end
        rd_en = 1'b0;
        check("rd_valid pulses", 64'(k), 64'(v.count));
        check("idle after read done", 64'(done), 64'd0);
        check("idle after read armed", 64'(armed), 64'd0);
        check("rd_left after read", 64'(rd_left), 64'd0);
        tick();
        check("rd_valid quiet", 64'(rd_valid), 64'd0);
        check("rd_data held", 64'(rd_data[31:0]), 64'(last[31:0]));
    endtask

    task automatic applyStimulus(input vec_t v);
        capture_only(v);
        read_out(v);
    endtask

    initial begin
        vecs[0] = '{2'd0, 32'd8,         32'hFFFF_FFFF, 5'd3,  1'b0, 8, 11, 12, 0};
        vecs[1] = '{2'd0, 32'd30,        32'hFFFF_FFFF, 5'd5,  1'b0, 30, 35, 16, 20};
        vecs[2] = '{2'd0, 32'd0,         32'hFFFF_FFFF, 5'd0,  1'b0, 0, 0, 1, 0};
        vecs[3] = '{2'd0, 32'd0,         32'hFFFF_FFFF, 5'd20, 1'b0, 0, 15, 16, 0};
        vecs[4] = '{2'd3, 32'h0000_0100, 32'h0000_0F00, 5'd0,  1'b0, 1, 1, 2, 0};
        vecs[5] = '{2'd0, 32'd5,         32'h0000_0000, 5'd2,  1'b0, 0, 2, 3, 0};
        vecs[6] = '{2'd0, 32'd8,         32'hFFFF_FFFF, 5'd4,  1'b1, 8, 12, 13, 0};
        vecs[7] = '{2'd1, 32'd107,       32'hFFFF_FFFF, 5'd1,  1'b0, 7, 8, 9, 0};

        reset       = 1'b1;
        probe_in    = '0;
        probe_valid = 1'b0;
        arm         = 1'b0;
        trig_chan   = '0;
        trig_value  = '0;
        trig_mask   = '0;
        post_count  = '0;
        rd_en       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_zero_outputs("reset");

        for (int n = 0; n < 8; n++) begin
            $display("[TB] scenario %0d", n);
            applyStimulus(vecs[n]);
        end

        // Arm while DONE discards the pending capture and starts fresh.
        capture_only(vecs[2]);
        applyStimulus(vecs[5]);

        // Reset during POST.
        trig_chan  = 2'd0;
        trig_value = 32'd8;
        trig_mask  = 32'hFFFF_FFFF;
        post_count = 5'd10;
        arm        = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            probe_valid = 1'b1;
            probe_in    = mk(i);
            tick();
        end
        probe_valid = 1'b0;
        check("post before reset armed", 64'(armed), 64'd1);
        reset = 1'b1;
        #2;
        check_zero_outputs("reset in post");
        reset = 1'b0;
        applyStimulus(vecs[0]);

        // Reset mid-readout.
        capture_only(vecs[1]);
        rd_en = 1'b1;
        repeat (3) tick();
        rd_en = 1'b0;
        check("mid read rd_left", 64'(rd_left), 64'd13);
        reset = 1'b1;
        #2;
        check_zero_outputs("reset in read");
        reset = 1'b0;
        applyStimulus(vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/probe_trace_buffer.md
# probe_trace_buffer

Synthesizable, parametrised trace capture for the pipelined processor: records up to CHANNELS probe words (e.g. instr, reg_check, data_mem_check, Rc) per valid cycle into a circular buffer. It stops after a programmable trigger plus post-trigger window, then plays the captured window back oldest-first over a read handshake. It replaces passive waveform-only observation with on-chip, self-checkable capture usable in simulation and on hardware.

## Interface
- WIDTH, 32, bits per probe channel
- CHANNELS, 4, number of probe channels (≥1)
- DEPTH, 16, buffer entries; power of two, ≥2
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- probe_in  in  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- probe_valid  in  1  sample qualifier
- arm  in  1  start a capture (latches config)
- trig_chan  in  $clog2(CHANNELS) (min 1)  channel compared for trigger
- trig_value  in  WIDTH  trigger compare value
- trig_mask  in  WIDTH  1 = bit participates in compare
- post_count  in  $clog2(DEPTH)+1  samples written after trigger sample
- rd_en  in  1  request next stored entry
- rd_data  out  CHANNELS*WIDTH  playback entry
- rd_valid  out  1  rd_data valid (one-cycle pulse)
- rd_left  out  $clog2(DEPTH)+1  entries not yet requested
- armed  out  1  state is ARMED or POST
- triggered  out  1  trigger seen in this capture
- done  out  1  state is DONE

## Operation
- States: IDLE, ARMED, POST, DONE.
- IDLE: no writes. arm → ARMED. On the same edge: latch trig_chan/value/mask and post_count clamped to DEPTH-1; wr_ptr=0, fill=0, triggered=0.
- ARMED: each probe_valid cycle writes probe_in at wr_ptr. wr_ptr increments modulo DEPTH. fill saturates at DEPTH.
- Trigger: probe_valid && ((chan[trig_chan] ^ trig_value) & trig_mask) == 0 while ARMED. The triggering sample is written and triggered=1. Latched post_count 0 → DONE; else → POST with remain=post_count.
- POST: each valid sample written; remain decrements; the write that takes remain to 0 → DONE.
- probe_valid=0 cycles: no write, no count, no trigger.
- DONE: rd_left=fill. rd_ptr = oldest entry (wr_ptr if fill==DEPTH, else 0). rd_en with rd_left>0 reads rd_ptr, increments rd_ptr mod DEPTH, decrements rd_left. rd_en with rd_left==0 is ignored. The edge that issues the last read → IDLE.
- arm in DONE: discard the capture and restart as from IDLE. arm in ARMED/POST: ignored.
- trig_mask=0: first valid sample triggers.

## Timing
- Reset: state IDLE. rd_data=0, rd_valid=0, rd_left=0, armed=0, triggered=0, done=0. Buffer contents are not reset. Reset mid-capture or mid-readout aborts immediately.
- Write and trigger detection happen on the same edge as the sample; the trigger compare is combinational on the current probe_in.
- done/armed/triggered are registered: they reflect the state after the edge.
- Read latency 1: rd_en at edge n → rd_data, rd_valid=1 after edge n+1. Back-to-back rd_en gives one entry per cycle. rd_valid for the last entry occurs in IDLE.
- rd_data holds its last value when rd_valid=0.

## Structure
- Package trace_pkg: state enum (2-bit: IDLE=0, ARMED=1, POST=2, DONE=3), clog2-derived width constants.
- Sub-module trace_ram: simple dual-port RAM, DEPTH × CHANNELS*WIDTH, one synchronous write port and one synchronous read port. Top level holds the FSM, pointers and counters.

## Test plan
Defaults: WIDTH=32, CHANNELS=4, DEPTH=16. Channel 0 = sample index i.
- Partial fill: arm; trig ch0 value 8, mask FFFFFFFF, post 3; feed i=0..40 → done after i=11, rd_left=12; reads return ch0 0..11 in order, then IDLE.
- Wrap: trig value 30, post 5 → 36 writes, buffer full; reads return ch0 20..35 (16 entries).
- Immediate: post 0, trig value 0 → done after first sample; exactly one rd_valid, ch0=0. post_count=20 is clamped to 15.
- Mask: ch3 = 0xABCD0000 then 0xABCD0100; trig_chan 3, value 0x00000100, mask 0x00000F00 → trigger on the second sample, triggered=1.
- Gaps and overread: probe_valid low on alternate cycles during POST (post 4) → exactly 4 post samples stored. rd_en held 20 cycles → 16 rd_valid pulses, extra requests ignored.
- Reset: assert reset during POST and again mid-readout → all outputs 0, IDLE. A new arm then captures correctly.
